fifo_spram_8to16: RTL

- Byte-in, word-out FIFO on one SB_SPRAM256KA (16K x 16). This is the reverse packing of the 16-bit-write / 8-bit-read hex FIFO.
- Accepts a byte stream (e.g. UART receive of a program image), packs consecutive byte pairs into 16-bit words and stores them.
- Presents the words to the TMS9900 side through a show-ahead output register.
- The single SPRAM port is arbitrated between word commits and read prefetches.

---
 rtl/fifo_spram_8to16_if.sv | 30 +++
 rtl/fifo_spram_8to16.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fifo_spram_8to16_if.sv
// fifo_spram_8to16_if
// Groups the byte-side write handshake and the word-side read handshake of
// fifo_spram_8to16.
//   write_data/write_strobe/flush : byte producer -> FIFO
//   full/byte_pending             : FIFO -> byte producer
//   read_data/data_available      : FIFO -> word consumer (show-ahead head)
//   read_strobe                   : word consumer -> FIFO
//   words                         : words stored in the SPRAM
// The slave modport is the FIFO's view; the master modport is the user's view.
interface fifo_spram_8to16_if;
    logic [7:0]  write_data;
    logic        write_strobe;
    logic        flush;
    logic        full;
    logic        byte_pending;
    logic [15:0] read_data;
    logic        data_available;
    logic        read_strobe;
    logic [14:0] words;

    modport slave (
        input  write_data, write_strobe, flush, read_strobe,
        output full, byte_pending, read_data, data_available, words
    );

    modport master (
        output write_data, write_strobe, flush, read_strobe,
        input  full, byte_pending, read_data, data_available, words
    );
endinterface

// File: rtl/fifo_spram_8to16.sv
// fifo_spram_8to16
// Byte-in, word-out FIFO built on one 16K x 16 single-port RAM.
// Consecutive byte pairs are packed into 16-bit words and stored. The words
// are presented through a show-ahead output register. The single RAM port is
// shared between word commits, which always win, and read prefetches.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-low (0 = reset)
//   bus   : fifo_spram_8to16_if.slave (byte write side, word read side)
// Parameters:
//   BIG_ENDIAN : 1 = first byte of a pair lands in [15:8], 0 = in [7:0]
//   BITS       : word address width; fixed at 14 (whole SPRAM)
module fifo_spram_8to16 #(
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int BITS       = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    fifo_spram_8to16_if.slave     bus
);
    localparam int DEPTH = 1 << BITS;

    // Pointers carry one extra bit so that full and empty are distinguishable.
    logic [BITS:0]   wr_ptr_reg, wr_ptr_next;
    logic [BITS:0]   rd_ptr_reg, rd_ptr_next;
    logic            byte_pending_reg, byte_pending_next;
    logic [7:0]      hold_reg, hold_next;
    logic            out_valid_reg, out_valid_next;
    logic            read_pending_reg, read_pending_next;
    logic [15:0]     read_data_reg, read_data_next;

    logic [BITS:0]   words;
    logic            full;
    logic            latch_byte;
    logic            commit;
    logic            issue;
    logic            consume;
    logic [7:0]      second_byte;

    // RAM port signals (modelled after SB_SPRAM256KA; the standby/sleep
    // controls are fixed to the awake state, so only CHIPSELECT matters).
    logic            chip_select;
    logic            wren;
    logic [BITS-1:0] address;
    logic [15:0]     datain;
    logic [15:0]     dataout_reg;
    logic [15:0]     mem [0:DEPTH-1];

    assign words = wr_ptr_reg - rd_ptr_reg;
    assign full  = (words == (BITS+1)'(DEPTH));

    // Full blocks both byte acceptance and flush; the hold byte survives.
    assign latch_byte = !full && bus.write_strobe && !byte_pending_reg;
    // A strobe with a byte already held completes the pair; a flush on its
    // own pads the pending byte. A strobe in the same cycle supersedes flush.
    assign commit     = !full && byte_pending_reg && (bus.write_strobe || bus.flush);
    assign consume    = bus.read_strobe && out_valid_reg;
    // Only one read may be in flight, so prefetch never needs a second slot.
    assign issue      = !commit && !read_pending_reg && (words != '0) &&
                        (!out_valid_reg || bus.read_strobe);

    assign second_byte = bus.write_strobe ? bus.write_data : 8'h00;

    always_comb begin
        datain = {second_byte, hold_reg};
        if (BIG_ENDIAN) begin
            datain = {hold_reg, second_byte};
        end
    end

    assign chip_select = reset;
    assign wren        = commit;
    assign address     = commit ? wr_ptr_reg[BITS-1:0] : rd_ptr_reg[BITS-1:0];

    // Single-port RAM with registered read; DATAOUT keeps its last read value
    // across write cycles, which the capture logic relies on.
    always_ff @(posedge clk) begin
        if (chip_select) begin
            if (wren) begin
                mem[address] <= datain;
            end else begin
                dataout_reg <= mem[address];
            end
        end
    end

    always_comb begin
        wr_ptr_next       = wr_ptr_reg;
        rd_ptr_next       = rd_ptr_reg;
        byte_pending_next = byte_pending_reg;
        hold_next         = hold_reg;
        out_valid_next    = out_valid_reg;
        read_pending_next = 1'b0;
        read_data_next    = read_data_reg;

        if (latch_byte) begin
            hold_next         = bus.write_data;
            byte_pending_next = 1'b1;
        end
        if (commit) begin
            wr_ptr_next       = wr_ptr_reg + 1'b1;
            byte_pending_next = 1'b0;
        end
        if (issue) begin
            rd_ptr_next       = rd_ptr_reg + 1'b1;
            read_pending_next = 1'b1;
        end

        // A capture on the same edge as a consume replaces the head word.
        if (read_pending_reg) begin
            read_data_next = dataout_reg;
            out_valid_next = 1'b1;
        end else if (consume) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            byte_pending_reg <= 1'b0;
            hold_reg         <= 8'h00;
            out_valid_reg    <= 1'b0;
            read_pending_reg <= 1'b0;
            read_data_reg    <= 16'h0000;
        end else begin
            wr_ptr_reg       <= wr_ptr_next;
            rd_ptr_reg       <= rd_ptr_next;
            byte_pending_reg <= byte_pending_next;
            hold_reg         <= hold_next;
            out_valid_reg    <= out_valid_next;
            read_pending_reg <= read_pending_next;
            read_data_reg    <= read_data_next;
        end
    end

    assign bus.full           = full;
    assign bus.byte_pending   = byte_pending_reg;
    assign bus.read_data      = read_data_reg;
    assign bus.data_available = out_valid_reg;
    assign bus.words          = words;
endmodule
